// File: rtl/samp_group_iter.sv
// Sample-group sequencer: latches one triangle and its snapped bounding box,
// then walks the box in raster order emitting SAMPS adjacent sample positions per cycle.
module samp_group_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS-1:0][AXIS-1:0],
    input  logic        [SIGFIG-1:0] color_R13U  [COLORS-1:0],
    input  logic signed [SIGFIG-1:0] box_R13S    [1:0][1:0],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S    [VERTS-1:0][AXIS-1:0],
    output logic        [SIGFIG-1:0] color_R14U  [COLORS-1:0],
    output logic signed [SIGFIG-1:0] sample_R14S [1:0][SAMPS-1:0],
    output logic        [SAMPS-1:0]  validSamp_R14H
);

    typedef enum logic [0:0] {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    localparam int W1 = SIGFIG + 1;

    // Widen a position by one bit so sums near the positive edge never wrap.
    function automatic logic signed [W1-1:0] sext(input logic signed [SIGFIG-1:0] v);
        return $signed({v[SIGFIG-1], v});
    endfunction

    // Decode the one-hot subsample select into a fixed-point step; anything else means one pixel.
    function automatic logic signed [SIGFIG-1:0] step_sel(input logic [3:0] sub);
        logic [SIGFIG-1:0] one_v;
        logic [SIGFIG-1:0] res_v;
        one_v = {{(SIGFIG-1){1'b0}}, 1'b1};
        case (sub)
            4'b1000: res_v = one_v << RADIX;
            4'b0100: res_v = one_v << (RADIX - 1);
            4'b0010: res_v = one_v << (RADIX - 2);
            4'b0001: res_v = one_v << (RADIX - 3);
            default: res_v = one_v << RADIX;
        endcase
        return $signed(res_v);
    endfunction

    state_t                   state_r;
    logic signed [SIGFIG-1:0] cur_x_r;
    logic signed [SIGFIG-1:0] cur_y_r;
    logic signed [SIGFIG-1:0] llx_r;
    logic signed [SIGFIG-1:0] urx_r;
    logic signed [SIGFIG-1:0] ury_r;
    logic signed [SIGFIG-1:0] step_r;

    state_t                   nxt_state_s;
    logic signed [SIGFIG-1:0] nxt_cur_x_s;
    logic signed [SIGFIG-1:0] nxt_cur_y_s;
    logic signed [SIGFIG-1:0] nxt_llx_s;
    logic signed [SIGFIG-1:0] nxt_urx_s;
    logic signed [SIGFIG-1:0] nxt_ury_s;
    logic signed [SIGFIG-1:0] nxt_step_s;
    logic                     load_s;
    logic signed [W1-1:0]     adv_x_s;
    logic signed [W1-1:0]     adv_y_s;
    logic signed [W1-1:0]     lane_x_s [SAMPS-1:0];
    logic        [SAMPS-1:0]  nxt_valid_s;

    // Next-state, acceptance and raster-advance decision.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cur_x_s = cur_x_r;
        nxt_cur_y_s = cur_y_r;
        nxt_llx_s   = llx_r;
        nxt_urx_s   = urx_r;
        nxt_ury_s   = ury_r;
        nxt_step_s  = step_r;
        load_s      = 1'b0;
        adv_x_s     = sext(cur_x_r) + (sext(step_r) <<< 2);
        adv_y_s     = sext(cur_y_r) + sext(step_r);
        case (state_r)
            WAIT: begin
                if (validTri_R13H) begin
                    load_s      = 1'b1;
                    nxt_llx_s   = box_R13S[0][0];
                    nxt_urx_s   = box_R13S[1][0];
                    nxt_ury_s   = box_R13S[1][1];
                    nxt_step_s  = step_sel(subSample_RnnnnU);
                    nxt_cur_x_s = box_R13S[0][0];
                    nxt_cur_y_s = box_R13S[0][1];
                    // An inverted box has no samples; drop it without leaving WAIT.
                    if ((box_R13S[0][0] > box_R13S[1][0]) || (box_R13S[0][1] > box_R13S[1][1])) begin
                        nxt_state_s = WAIT;
                    end else begin
                        nxt_state_s = TEST;
                    end
                end else begin
                    nxt_state_s = WAIT;
                end
            end
            TEST: begin
                if (adv_x_s <= sext(urx_r)) begin
                    nxt_cur_x_s = $signed(adv_x_s[SIGFIG-1:0]);
                end else if (adv_y_s <= sext(ury_r)) begin
                    nxt_cur_x_s = llx_r;
                    nxt_cur_y_s = $signed(adv_y_s[SIGFIG-1:0]);
                end else begin
                    nxt_state_s = WAIT;
                end
            end
            default: begin
                nxt_state_s = WAIT;
            end
        endcase
    end

    // Lane positions and validity for the group that will be shown next cycle.
    always_comb begin
        logic signed [W1-1:0] acc_v;
        acc_v       = sext(nxt_cur_x_s);
        nxt_valid_s = {SAMPS{1'b0}};
        for (int s = 0; s < SAMPS; s++) begin
            lane_x_s[s] = acc_v;
            acc_v       = acc_v + sext(nxt_step_s);
            if ((nxt_state_s == TEST) && (lane_x_s[s] <= sext(nxt_urx_s))) begin
                nxt_valid_s[s] = 1'b1;
            end else begin
                nxt_valid_s[s] = 1'b0;
            end
        end
    end

    // State, traversal registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= WAIT;
            cur_x_r        <= '0;
            cur_y_r        <= '0;
            llx_r          <= '0;
            urx_r          <= '0;
            ury_r          <= '0;
            step_r         <= '0;
            halt_RnnnnL    <= 1'b1;
            validSamp_R14H <= '0;
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    tri_R14S[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                color_R14U[c] <= '0;
            end
            for (int s = 0; s < SAMPS; s++) begin
                sample_R14S[0][s] <= '0;
                sample_R14S[1][s] <= '0;
            end
        end else begin
            state_r        <= nxt_state_s;
            cur_x_r        <= nxt_cur_x_s;
            cur_y_r        <= nxt_cur_y_s;
            llx_r          <= nxt_llx_s;
            urx_r          <= nxt_urx_s;
            ury_r          <= nxt_ury_s;
            step_r         <= nxt_step_s;
            halt_RnnnnL    <= (nxt_state_s == WAIT);
            validSamp_R14H <= nxt_valid_s;
            if (load_s) begin
                for (int v = 0; v < VERTS; v++) begin
                    for (int a = 0; a < AXIS; a++) begin
                        tri_R14S[v][a] <= tri_R13S[v][a];
                    end
                end
                for (int c = 0; c < COLORS; c++) begin
                    color_R14U[c] <= color_R13U[c];
                end
            end
            if (nxt_state_s == TEST) begin
                for (int s = 0; s < SAMPS; s++) begin
                    sample_R14S[0][s] <= $signed(lane_x_s[s][SIGFIG-1:0]);
                    sample_R14S[1][s] <= nxt_cur_y_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_samp_group_iter.sv
// Scoreboard bench for samp_group_iter: stimulus pushes hand-computed groups,
// a negedge monitor pops and compares every group the DUT presents.
module tb_samp_group_iter;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] tri_in   [2:0][2:0];
    logic        [23:0] col_in   [2:0];
    logic signed [23:0] box_in   [1:0][1:0];
    logic               valid_tri;
    logic        [3:0]  sub;
    logic               halt;
    logic signed [23:0] tri_out  [2:0][2:0];
    logic        [23:0] col_out  [2:0];
    logic signed [23:0] samp_out [1:0][3:0];
    logic        [3:0]  vsamp;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0][23:0] x;
        logic [23:0]      y;
        logic [3:0]       v;
        int               tb;
    } exp_t;

    exp_t q[$];

    samp_group_iter dut (
        .clk(clk), .rst(rst),
        .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box_in),
        .validTri_R13H(valid_tri), .subSample_RnnnnU(sub),
        .halt_RnnnnL(halt), .tri_R14S(tri_out), .color_R14U(col_out),
        .sample_R14S(samp_out), .validSamp_R14H(vsamp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] s, input int tb);
        box_in[0][0] = 24'(llx);
        box_in[0][1] = 24'(lly);
        box_in[1][0] = 24'(urx);
        box_in[1][1] = 24'(ury);
        sub = s;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_in[v][a] = 24'(tb * 256 + v * 16 + a);
        for (int c = 0; c < 3; c++)
            col_in[c] = 24'(tb * 2 + c + 100);
    endtask

    task automatic push(input int x0, input int x1, input int x2, input int x3,
                        input int y, input logic [3:0] v, input int tb);
        exp_t e;
        e.x[0] = 24'(x0); e.x[1] = 24'(x1); e.x[2] = 24'(x2); e.x[3] = 24'(x3);
        e.y = 24'(y); e.v = v; e.tb = tb;
        q.push_back(e);
    endtask

    task automatic send(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] s, input int tb);
        @(negedge clk);
        set_box(llx, lly, urx, ury, s, tb);
        valid_tri = 1'b1;
        @(negedge clk);
        valid_tri = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_groups);
        int cnt = 0;
        while (halt == 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk({name, "_groups"}, 64'(cnt), 64'(exp_groups));
        chk({name, "_idle_valid"}, 64'(vsamp), 64'h0);
    endtask

    // Monitor: every presented group must match the head of the scoreboard.
    always @(negedge clk) begin
        if (vsamp != 4'b0000) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_group: got valid %b x0 %0d y %0d, expected none",
                         vsamp, samp_out[0][0], samp_out[1][0]);
            end else begin
                exp_t e;
                logic ok;
                e = q.pop_front();
                ok = (vsamp == e.v);
                for (int s = 0; s < 4; s++) begin
                    if (samp_out[0][s] !== $signed(e.x[s])) ok = 1'b0;
                    if (samp_out[1][s] !== $signed(e.y)) ok = 1'b0;
                end
                n_vec++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL group: got v=%b x=%0d/%0d/%0d/%0d y=%0d expected v=%b x=%0d/%0d/%0d/%0d y=%0d",
                             vsamp, samp_out[0][0], samp_out[0][1], samp_out[0][2], samp_out[0][3],
                             samp_out[1][0], e.v, e.x[0], e.x[1], e.x[2], e.x[3], e.y);
                end
                ok = 1'b1;
                for (int v = 0; v < 3; v++)
                    for (int a = 0; a < 3; a++)
                        if (tri_out[v][a] !== 24'(e.tb * 256 + v * 16 + a)) ok = 1'b0;
                for (int c = 0; c < 3; c++)
                    if (col_out[c] !== 24'(e.tb * 2 + c + 100)) ok = 1'b0;
                n_vec++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL hold: got tri00=%0d col0=%0d expected tri00=%0d col0=%0d",
                             tri_out[0][0], col_out[0], e.tb * 256, e.tb * 2 + 100);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        valid_tri = 1'b0;
        set_box(0, 0, 0, 0, 4'b1000, 0);
        repeat (2) @(negedge clk);
        chk("rst_halt", 64'(halt), 64'h1);
        chk("rst_valid", 64'(vsamp), 64'h0);
        chk("rst_samp", 64'(samp_out[0][1]), 64'h0);
        chk("rst_tri", 64'(tri_out[2][2]), 64'h0);
        chk("rst_col", 64'(col_out[1]), 64'h0);
        rst = 1'b0;

        // 4x2 pixel box, full groups
        push(0, 1024, 2048, 3072, 0, 4'b1111, 1);
        push(0, 1024, 2048, 3072, 1024, 4'b1111, 1);
        send(0, 0, 3072, 1024, 4'b1000, 1);
        wait_idle("t1", 2);

        // six columns: partial second group
        push(0, 1024, 2048, 3072, 0, 4'b1111, 2);
        push(4096, 5120, 6144, 7168, 0, 4'b0011, 2);
        send(0, 0, 5120, 0, 4'b1000, 2);
        wait_idle("t2", 2);

        // half-pixel step
        push(0, 512, 1024, 1536, 0, 4'b0011, 3);
        push(0, 512, 1024, 1536, 512, 4'b0011, 3);
        send(0, 0, 512, 512, 4'b0100, 3);
        wait_idle("t3", 2);

        // single-sample box
        push(2048, 3072, 4096, 5120, 2048, 4'b0001, 4);
        send(2048, 2048, 2048, 2048, 4'b1000, 4);
        wait_idle("t4", 1);

        // inverted box is dropped
        send(1024, 0, 0, 0, 4'b1000, 5);
        for (int i = 0; i < 3; i++) begin
            chk("t5_halt", 64'(halt), 64'h1);
            @(negedge clk);
        end

        // non-one-hot select behaves as one pixel
        push(0, 1024, 2048, 3072, 0, 4'b1111, 6);
        push(0, 1024, 2048, 3072, 1024, 4'b1111, 6);
        send(0, 0, 3072, 1024, 4'b0110, 6);
        wait_idle("t6", 2);

        // back-to-back with valid held high: one bubble cycle
        push(0, 1024, 2048, 3072, 0, 4'b1111, 8);
        push(0, 1024, 2048, 3072, 1024, 4'b1111, 8);
        push(0, 512, 1024, 1536, 0, 4'b0011, 9);
        push(0, 512, 1024, 1536, 512, 4'b0011, 9);
        @(negedge clk);
        set_box(0, 0, 3072, 1024, 4'b1000, 8);
        valid_tri = 1'b1;
        @(negedge clk);
        chk("b2b_c1_halt", 64'(halt), 64'h0);
        @(negedge clk);
        chk("b2b_c2_halt", 64'(halt), 64'h0);
        @(negedge clk);
        chk("b2b_bubble_halt", 64'(halt), 64'h1);
        chk("b2b_bubble_valid", 64'(vsamp), 64'h0);
        set_box(0, 0, 512, 512, 4'b0100, 9);
        @(negedge clk);
        chk("b2b_c4_halt", 64'(halt), 64'h0);
        valid_tri = 1'b0;
        wait_idle("b2b", 2);

        // reset during group 3 of 6
        push(0, 1024, 2048, 3072, 0, 4'b1111, 10);
        push(4096, 5120, 6144, 7168, 0, 4'b1111, 10);
        push(0, 1024, 2048, 3072, 1024, 4'b1111, 10);
        send(0, 0, 7168, 2048, 4'b1000, 10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_halt", 64'(halt), 64'h1);
        chk("mid_rst_valid", 64'(vsamp), 64'h0);
        chk("mid_rst_samp", 64'(samp_out[0][0]), 64'h0);
        chk("mid_rst_tri", 64'(tri_out[0][1]), 64'h0);
        rst = 1'b0;
        push(0, 1024, 2048, 3072, 0, 4'b1111, 11);
        push(0, 1024, 2048, 3072, 1024, 4'b1111, 11);
        send(0, 0, 3072, 1024, 4'b1000, 11);
        wait_idle("post_rst", 2);

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
